// File: rtl/img_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | img_seq_pkg : shared types and helpers for the image line sequencer  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package img_seq_pkg;

  // Width of the address fields held in the shadow config.
  // Raise this if the sequencer is built with a wider ADDR_WIDTH.
  localparam int CFG_ADDR_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic [CFG_ADDR_W-1:0] baddr;
    logic [CFG_ADDR_W-1:0] pitch;
    logic [7:0]            hsize;
    logic [7:0]            vsize;
    logic [7:0]            minx;
    logic [7:0]            miny;
  } img_cfg_t;

  function automatic logic [31:0] pix2byte(input logic [7:0] pix, input int bpp);
    return 32'(pix) * 32'(bpp);
  endfunction

endpackage
`default_nettype wire

// File: rtl/img_seq_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | img_seq_addr_gen : window origin address and per-line pitch stepping |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module img_seq_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int BPP_BYTES  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] baddr,
  input  logic [ADDR_WIDTH-1:0] pitch,
  input  logic [7:0]            minx,
  input  logic [7:0]            miny,
  output logic [ADDR_WIDTH-1:0] line_addr
);
  import img_seq_pkg::*;

  logic [ADDR_WIDTH-1:0] row_offset;
  logic [ADDR_WIDTH-1:0] col_offset;
  logic [ADDR_WIDTH-1:0] origin_addr;

  // All sums are modulo 2^ADDR_WIDTH so a window may wrap the address space.
  always_comb begin
    row_offset  = ADDR_WIDTH'(miny) * pitch;
    col_offset  = ADDR_WIDTH'(pix2byte(minx, BPP_BYTES));
    origin_addr = baddr + row_offset + col_offset;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_addr <= '0;
    end else if (load) begin
      line_addr <= origin_addr;
    end else if (step) begin
      line_addr <= line_addr + pitch;
    end
  end

endmodule
`default_nettype wire

// File: rtl/img_line_dma_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | img_line_dma_sequencer : issues one DMA line command per window row  |
// | Optional macro IMG_SEQ_PERF_CNT_EN adds a busy-cycle perf counter    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module img_line_dma_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int BPP_BYTES  = 1,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cfg_baddr_i,
  input  logic [ADDR_WIDTH-1:0] cfg_pitch_i,
  input  logic [7:0]            cfg_hsize_i,
  input  logic [7:0]            cfg_vsize_i,
  input  logic [7:0]            cfg_minx_i,
  input  logic [7:0]            cfg_miny_i,
  input  logic                  cfg_st_i,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [ADDR_WIDTH-1:0] cmd_addr_o,
  output logic [LEN_WIDTH-1:0]  cmd_len_o,
  input  logic                  line_done_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           perf_cycles_o
);
  import img_seq_pkg::*;

  seq_state_e            state;
  seq_state_e            state_next;
  img_cfg_t              shadow;
  logic                  st_q;
  logic                  start;
  logic                  empty_frame;
  logic                  last_row;
  logic                  addr_load;
  logic                  addr_step;
  logic [7:0]            row;
  logic [ADDR_WIDTH-1:0] line_addr;

  // Edges arriving outside IDLE are dropped, not remembered.
  assign start       = cfg_st_i & ~st_q & (state == IDLE);
  assign empty_frame = (shadow.hsize == 8'd0) || (shadow.vsize == 8'd0);
  assign last_row    = (row == shadow.vsize - 8'd1);
  assign addr_load   = (state == CALC);
  assign addr_step   = (state == WAIT) & line_done_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= 1'b0;
    end else begin
      st_q <= cfg_st_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (start) begin
      shadow <= '{baddr: CFG_ADDR_W'(cfg_baddr_i),
                  pitch: CFG_ADDR_W'(cfg_pitch_i),
                  hsize: cfg_hsize_i,
                  vsize: cfg_vsize_i,
                  minx:  cfg_minx_i,
                  miny:  cfg_miny_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= 8'd0;
    end else if (addr_load) begin
      row <= 8'd0;
    end else if (addr_step) begin
      row <= row + 8'd1;
    end
  end

  img_seq_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BPP_BYTES  (BPP_BYTES)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (addr_load),
    .step      (addr_step),
    .baddr     (ADDR_WIDTH'(shadow.baddr)),
    .pitch     (ADDR_WIDTH'(shadow.pitch)),
    .minx      (shadow.minx),
    .miny      (shadow.miny),
    .line_addr (line_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    cmd_valid_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start) state_next = CALC;
      end
      CALC: begin
        state_next = empty_frame ? DONE : ISSUE;
      end
      ISSUE: begin
        cmd_valid_o = 1'b1;
        if (cmd_ready_i) state_next = WAIT;
      end
      WAIT: begin
        if (line_done_i) state_next = last_row ? DONE : ISSUE;
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy_o     = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign cmd_addr_o = line_addr;
  assign cmd_len_o  = LEN_WIDTH'(pix2byte(shadow.hsize, BPP_BYTES));

`ifdef IMG_SEQ_PERF_CNT_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt <= 32'd0;
    end else if (start) begin
      perf_cnt <= 32'd0;
    end else if (busy_o && (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign perf_cycles_o = perf_cnt;
`else
  assign perf_cycles_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_img_line_dma_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_img_line_dma_sequencer : randomized bench with a frame-level model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_img_line_dma_sequencer;

  localparam int AW  = 32;
  localparam int BPP = 1;
  localparam int LW  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] cfg_baddr_i;
  logic [AW-1:0] cfg_pitch_i;
  logic [7:0]    cfg_hsize_i;
  logic [7:0]    cfg_vsize_i;
  logic [7:0]    cfg_minx_i;
  logic [7:0]    cfg_miny_i;
  logic          cfg_st_i;
  logic          cmd_valid_o;
  logic          cmd_ready_i;
  logic [AW-1:0] cmd_addr_o;
  logic [LW-1:0] cmd_len_o;
  logic          line_done_i;
  logic          busy_o;
  logic          done_o;
  logic [31:0]   perf_cycles_o;

  always #5 clk = ~clk;

  img_line_dma_sequencer #(
    .ADDR_WIDTH (AW),
    .BPP_BYTES  (BPP),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_baddr_i   (cfg_baddr_i),
    .cfg_pitch_i   (cfg_pitch_i),
    .cfg_hsize_i   (cfg_hsize_i),
    .cfg_vsize_i   (cfg_vsize_i),
    .cfg_minx_i    (cfg_minx_i),
    .cfg_miny_i    (cfg_miny_i),
    .cfg_st_i      (cfg_st_i),
    .cmd_valid_o   (cmd_valid_o),
    .cmd_ready_i   (cmd_ready_i),
    .cmd_addr_o    (cmd_addr_o),
    .cmd_len_o     (cmd_len_o),
    .line_done_i   (line_done_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .perf_cycles_o (perf_cycles_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  // A frame is a list of line addresses; lines leave the list on handshake.
  bit          m_busy, m_done_now, m_waiting, m_st_prev;
  int          m_lead;
  bit [31:0]   m_q[$];
  bit [15:0]   m_len;
  bit [31:0]   m_perf;

  function automatic bit m_valid();
    return m_busy && !m_done_now && !m_waiting && (m_lead == 0) && (m_q.size() > 0);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_done_now = 0; m_waiting = 0; m_st_prev = 0;
      m_lead = 0; m_len = 0; m_perf = 0;
      m_q.delete();
    end else begin
      bit fire;
      fire = m_valid() && cmd_ready_i;
      if (m_busy && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
      if (m_done_now) begin
        m_done_now = 0;
        m_busy     = 0;
      end else if (!m_busy) begin
        if (cfg_st_i && !m_st_prev) begin
          m_busy = 1;
          m_lead = 1;
          m_perf = 0;
          m_len  = 16'(cfg_hsize_i * BPP);
          m_q.delete();
          if (cfg_hsize_i != 0)
            for (int r = 0; r < int'(cfg_vsize_i); r++)
              m_q.push_back(32'(cfg_baddr_i + (32'(cfg_miny_i) + 32'(r)) * cfg_pitch_i
                                + 32'(cfg_minx_i) * BPP));
        end
      end else if (m_lead > 0) begin
        m_lead = 0;
        if (m_q.size() == 0) m_done_now = 1;
      end else if (fire) begin
        void'(m_q.pop_front());
        m_waiting = 1;
      end else if (m_waiting && line_done_i) begin
        m_waiting = 0;
        if (m_q.size() == 0) m_done_now = 1;
      end
      m_st_prev = cfg_st_i;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("busy", 64'(busy_o), 64'(m_busy));
    chk("done", 64'(done_o), 64'(m_done_now));
    chk("cmd_valid", 64'(cmd_valid_o), 64'(m_valid()));
    if (m_valid()) begin
      chk("cmd_addr", 64'(cmd_addr_o), 64'(m_q[0]));
      chk("cmd_len", 64'(cmd_len_o), 64'(m_len));
    end
`ifdef IMG_SEQ_PERF_CNT_EN
    chk("perf", 64'(perf_cycles_o), 64'(m_perf));
`else
    chk("perf_tied", 64'(perf_cycles_o), 64'd0);
`endif
    if (done_o) done_cnt++;
  end

  // ---------------- line master responder ----------------
  bit          force_low   = 0;
  bit          long_delay  = 0;
  bit [31:0]   got_addrs[$];
  bit [15:0]   got_len;

  initial begin
    bit outst;
    int dly;
    outst = 0; dly = 0;
    cmd_ready_i = 0; line_done_i = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        outst = 0; cmd_ready_i = 0; line_done_i = 0;
      end else begin
        line_done_i = 0;
        if (outst) begin
          if (dly == 0) begin line_done_i = 1; outst = 0; end
          else dly--;
        end else if ($urandom_range(0, 9) == 0) begin
          line_done_i = 1;  // stray pulse, must be ignored
        end
        cmd_ready_i = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (cmd_valid_o && cmd_ready_i) begin
          outst = 1;
          dly   = long_delay ? 10 : int'($urandom_range(0, 3));
          got_addrs.push_back(cmd_addr_o);
          got_len = cmd_len_o;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_frame(input bit [31:0] b, input bit [31:0] p, input bit [7:0] h,
                             input bit [7:0] v, input bit [7:0] x, input bit [7:0] y);
    cfg_baddr_i = b; cfg_pitch_i = p; cfg_hsize_i = h; cfg_vsize_i = v;
    cfg_minx_i = x; cfg_miny_i = y;
    got_addrs.delete();
    got_len = 0;
    @(negedge clk);
    cfg_st_i = 1;
  endtask

  task automatic run_frame(input bit [31:0] b, input bit [31:0] p, input bit [7:0] h,
                           input bit [7:0] v, input bit [7:0] x, input bit [7:0] y,
                           input bit mid_poke, output int lat);
    int n;
    start_frame(b, p, h, v, x, y);
    n = 0; lat = -1;
    while (n < 5000 && lat < 0) begin
      @(negedge clk);
      n++;
      if (mid_poke && n == 4) begin
        cfg_st_i = 0; cfg_pitch_i = p + 32'h1000; cfg_baddr_i = ~b; cfg_hsize_i = h + 8'd1;
      end
      if (mid_poke && n == 6) cfg_st_i = 1;
      if (done_o) lat = n;
    end
    chk("frame_done_seen", 64'(lat >= 0), 64'd1);
    @(negedge clk);
    cfg_st_i = 0;
    @(negedge clk);
  endtask

  initial begin
    int          lat, d0, n;
    bit [31:0]   exp1[4];
    bit [31:0]   exp4[5];
    bit [31:0]   exp5[3];
    bit [7:0]    h, v;
    exp1 = '{32'h8000_0102, 32'h8000_0202, 32'h8000_0302, 32'h8000_0402};
    exp4 = '{32'h4000_0400, 32'h4000_0600, 32'h4000_0800, 32'h4000_0A00, 32'h4000_0C00};
    exp5 = '{32'hFFFF_FF00, 32'hFFFF_FF80, 32'h0000_0000};

    rst_n = 0; cfg_st_i = 0;
    cfg_baddr_i = 0; cfg_pitch_i = 0; cfg_hsize_i = 0; cfg_vsize_i = 0;
    cfg_minx_i = 0; cfg_miny_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_valid", 64'(cmd_valid_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_addr", 64'(cmd_addr_o), 64'd0);
    chk("rst_len", 64'(cmd_len_o), 64'd0);
    chk("rst_perf", 64'(perf_cycles_o), 64'd0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Basic window
    d0 = done_cnt;
    run_frame(32'h8000_0000, 32'h100, 8'd16, 8'd4, 8'd2, 8'd1, 0, lat);
    chk("t1_nlines", 64'(got_addrs.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_addrs.size(); i++) chk("t1_addr", 64'(got_addrs[i]), 64'(exp1[i]));
    chk("t1_len", 64'(got_len), 64'd16);
    chk("t1_done_pulses", 64'(done_cnt - d0), 64'd1);

    // Backpressure: ready held low for 5 cycles on the first line
    force_low = 1;
    start_frame(32'h1000, 32'h40, 8'd8, 8'd2, 8'd1, 8'd0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid_held", 64'(cmd_valid_o), 64'd1);
      chk("t2_addr_stable", 64'(cmd_addr_o), 64'h1001);
      chk("t2_len_stable", 64'(cmd_len_o), 64'd8);
      @(negedge clk);
    end
    force_low = 0;
    n = 0;
    while (n < 2000 && !done_o) begin @(negedge clk); n++; end
    chk("t2_done_seen", 64'(done_o), 64'd1);
    cfg_st_i = 0;
    repeat (2) @(negedge clk);
    chk("t2_nlines", 64'(got_addrs.size()), 64'd2);
    if (got_addrs.size() == 2) chk("t2_addr1", 64'(got_addrs[1]), 64'h1041);

    // Empty window
    run_frame(32'h1234_0000, 32'h40, 8'd0, 8'd8, 8'd3, 8'd3, 0, lat);
    chk("t3_latency", 64'(lat), 64'd2);
    chk("t3_nlines", 64'(got_addrs.size()), 64'd0);
`ifdef IMG_SEQ_PERF_CNT_EN
    chk("t3_perf", 64'(perf_cycles_o), 64'd2);
`endif

    // ST re-toggled and config changed mid-frame
    d0 = done_cnt;
    run_frame(32'h4000_0000, 32'h200, 8'd8, 8'd5, 8'd0, 8'd2, 1, lat);
    chk("t4_nlines", 64'(got_addrs.size()), 64'd5);
    for (int i = 0; i < 5 && i < got_addrs.size(); i++) chk("t4_addr", 64'(got_addrs[i]), 64'(exp4[i]));
    repeat (4) @(negedge clk);
    chk("t4_no_restart", 64'(done_cnt - d0), 64'd1);

    // Address wrap
    run_frame(32'hFFFF_FF00, 32'h80, 8'd4, 8'd3, 8'd0, 8'd0, 0, lat);
    chk("t5_nlines", 64'(got_addrs.size()), 64'd3);
    for (int i = 0; i < 3 && i < got_addrs.size(); i++) chk("t5_addr", 64'(got_addrs[i]), 64'(exp5[i]));

    // Async reset while a line is outstanding
    long_delay = 1;
    d0 = done_cnt;
    start_frame(32'h2000, 32'h100, 8'd4, 8'd6, 8'd0, 8'd0);
    n = 0;
    while (got_addrs.size() == 0 && n < 200) begin @(negedge clk); n++; end
    chk("t6_first_line", 64'(got_addrs.size()), 64'd1);
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk("t6_rst_valid", 64'(cmd_valid_o), 64'd0);
    chk("t6_rst_busy", 64'(busy_o), 64'd0);
    chk("t6_rst_done", 64'(done_o), 64'd0);
    chk("t6_rst_addr", 64'(cmd_addr_o), 64'd0);
    cfg_st_i = 0;
    long_delay = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
    run_frame(32'h2000, 32'h100, 8'd4, 8'd3, 8'd0, 8'd0, 0, lat);
    chk("t6_nlines", 64'(got_addrs.size()), 64'd3);
    if (got_addrs.size() == 3) chk("t6_addr2", 64'(got_addrs[2]), 64'h2200);

    // Randomized frames
    for (int f = 0; f < 14; f++) begin
      h = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 24));
      v = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom_range(1, 10));
      if (f == 13) begin h = 8'd255; v = 8'd1; end
      run_frame($urandom, $urandom, h, v, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                (f % 3) == 0, lat);
      chk("rand_nlines", 64'(got_addrs.size()), (h == 0 || v == 0) ? 64'd0 : 64'(v));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
